// File: rtl/apb_i2c_pkg.sv
// Shared definitions for the APB register bank of the I2C bridge:
// register offsets (PADDR[4:2]), FSM states and STATUS/IRQ bit positions.
package apb_i2c_pkg;

  localparam logic [2:0] OFF_TXDATA   = 3'd0;
  localparam logic [2:0] OFF_RXDATA   = 3'd1;
  localparam logic [2:0] OFF_CONFIG   = 3'd2;
  localparam logic [2:0] OFF_TIMEOUT  = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;
  localparam logic [2:0] OFF_IRQ_EN   = 3'd5;
  localparam logic [2:0] OFF_IRQ_STAT = 3'd6;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int IRQ_TX  = 0;
  localparam int IRQ_RX  = 1;
  localparam int IRQ_ERR = 2;

  localparam int ST_RX_EMPTY = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_TX_FULL  = 2;
  localparam int ST_ERR      = 3;

endpackage

// File: rtl/apb_i2c_irq.sv
// Interrupt block: edge detection of FIFO/core flags, sticky W1C status,
// masking and registered interrupt outputs.
module apb_i2c_irq
  import apb_i2c_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_empty,
  input  logic       rx_empty,
  input  logic       error,
  input  logic [2:0] w1c,
  input  logic [2:0] irq_en,
  output logic [2:0] stat,
  output logic       int_tx,
  output logic       int_rx,
  output logic       int_err
);

  logic       tx_q, rx_q, err_q;
  logic [2:0] ev;

  always_comb begin
    ev          = '0;
    ev[IRQ_TX]  = tx_empty & ~tx_q;
    ev[IRQ_RX]  = rx_q & ~rx_empty;
    ev[IRQ_ERR] = error & ~err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Start from the current levels so a reset never fabricates an edge.
      tx_q    <= tx_empty;
      rx_q    <= rx_empty;
      err_q   <= error;
      stat    <= '0;
      int_tx  <= 1'b0;
      int_rx  <= 1'b0;
      int_err <= 1'b0;
    end else begin
      tx_q    <= tx_empty;
      rx_q    <= rx_empty;
      err_q   <= error;
      stat    <= (stat & ~w1c) | ev;
      int_tx  <= stat[IRQ_TX]  & irq_en[IRQ_TX];
      int_rx  <= stat[IRQ_RX]  & irq_en[IRQ_RX];
      int_err <= stat[IRQ_ERR] & irq_en[IRQ_ERR];
    end
  end

endmodule

// File: rtl/apb_i2c_regbank.sv
// APB3 slave register bank for the I2C bridge: address decode, wait-state FSM
// with bounded timeout on blocked FIFO accesses, and the register file.
module apb_i2c_regbank
  import apb_i2c_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int CFG_W    = 14,
  parameter int TO_W     = 14,
  parameter int WAIT_MAX = 15
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSELx,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [DATA_W-1:0] READ_DATA_ON_RX,
  input  logic              TX_FULL,
  input  logic              TX_EMPTY,
  input  logic              RX_EMPTY,
  input  logic              ERROR,
  output logic [DATA_W-1:0] WRITE_DATA_ON_TX,
  output logic              WR_ENA,
  output logic              RD_ENA,
  output logic [CFG_W-1:0]  I2C_CONFIG,
  output logic [TO_W-1:0]   I2C_TIMEOUT,
  output logic              INT_TX,
  output logic              INT_RX,
  output logic              INT_ERR
);

  localparam int WCNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_MAX - 1);

  state_t            state;
  logic [WCNT_W-1:0] wcnt;
  logic              op_tx;
  logic [2:0]        irq_en;
  logic [2:0]        irq_stat;
  logic [2:0]        off;
  logic              acc_err, is_tx, is_rx, blocked_now, blocked_wait, access;
  logic [2:0]        w1c;
  logic [DATA_W-1:0] rdata;

  assign off    = PADDR[4:2];
  assign access = PSELx & PENABLE;
  assign PREADY = (state == RESP);

  always_comb begin
    case (off)
      OFF_TXDATA:  acc_err = ~PWRITE;
      OFF_RXDATA,
      OFF_STATUS:  acc_err = PWRITE;
      OFF_CONFIG,
      OFF_TIMEOUT,
      OFF_IRQ_EN,
      OFF_IRQ_STAT: acc_err = 1'b0;
      default:     acc_err = 1'b1;
    endcase
    if (PADDR[31:5] != '0 || PADDR[1:0] != 2'b00) acc_err = 1'b1;
  end

  assign is_tx        = ~acc_err &  PWRITE & (off == OFF_TXDATA);
  assign is_rx        = ~acc_err & ~PWRITE & (off == OFF_RXDATA);
  assign blocked_now  = (is_tx & TX_FULL) | (is_rx & RX_EMPTY);
  assign blocked_wait = op_tx ? TX_FULL : RX_EMPTY;

  // W1C lands on the same edge that enters RESP, like every other register write.
  assign w1c = (state == IDLE && access && ~acc_err && PWRITE && off == OFF_IRQ_STAT)
               ? PWDATA[2:0] : 3'b000;

  always_comb begin
    rdata = '0;
    case (off)
      OFF_RXDATA:   rdata = READ_DATA_ON_RX;
      OFF_CONFIG:   rdata = DATA_W'(I2C_CONFIG);
      OFF_TIMEOUT:  rdata = DATA_W'(I2C_TIMEOUT);
      OFF_STATUS:   rdata = DATA_W'({irq_stat[IRQ_ERR], TX_FULL, TX_EMPTY, RX_EMPTY});
      OFF_IRQ_EN:   rdata = DATA_W'(irq_en);
      OFF_IRQ_STAT: rdata = DATA_W'(irq_stat);
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state            <= IDLE;
      wcnt             <= '0;
      op_tx            <= 1'b0;
      PSLVERR          <= 1'b0;
      PRDATA           <= '0;
      WR_ENA           <= 1'b0;
      RD_ENA           <= 1'b0;
      WRITE_DATA_ON_TX <= '0;
      I2C_CONFIG       <= '0;
      I2C_TIMEOUT      <= '0;
      irq_en           <= '0;
    end else begin
      WR_ENA <= 1'b0;
      RD_ENA <= 1'b0;
      case (state)
        IDLE: if (access) begin
          if (blocked_now) begin
            state <= WAIT;
            wcnt  <= '0;
            op_tx <= is_tx;
          end else begin
            state   <= RESP;
            PSLVERR <= acc_err;
            if (acc_err) PRDATA <= '0;
            else if (PWRITE) begin
              case (off)
                OFF_TXDATA:  begin WR_ENA <= 1'b1; WRITE_DATA_ON_TX <= PWDATA; end
                OFF_CONFIG:  I2C_CONFIG  <= PWDATA[CFG_W-1:0];
                OFF_TIMEOUT: I2C_TIMEOUT <= PWDATA[TO_W-1:0];
                OFF_IRQ_EN:  irq_en      <= PWDATA[2:0];
                default: ;
              endcase
            end else begin
              PRDATA <= rdata;
              RD_ENA <= is_rx;
            end
          end
        end
        WAIT: begin
          if (!PSELx) state <= IDLE;
          else if (!blocked_wait) begin
            state   <= RESP;
            PSLVERR <= 1'b0;
            if (op_tx) begin
              WR_ENA           <= 1'b1;
              WRITE_DATA_ON_TX <= PWDATA;
            end else begin
              RD_ENA <= 1'b1;
              PRDATA <= READ_DATA_ON_RX;
            end
          end else if (wcnt == WCNT_LAST) begin
            state   <= RESP;
            PSLVERR <= 1'b1;
            PRDATA  <= '0;
          end else wcnt <= wcnt + 1'b1;
        end
        RESP: begin
          state   <= IDLE;
          PSLVERR <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  apb_i2c_irq u_irq (
    .clk      (PCLK),
    .rst      (PRESET),
    .tx_empty (TX_EMPTY),
    .rx_empty (RX_EMPTY),
    .error    (ERROR),
    .w1c      (w1c),
    .irq_en   (irq_en),
    .stat     (irq_stat),
    .int_tx   (INT_TX),
    .int_rx   (INT_RX),
    .int_err  (INT_ERR)
  );

endmodule

// File: tb/tb_apb_i2c_regbank.sv
// Self-checking bench for apb_i2c_regbank: vector table, FIFO wait/timeout,
// interrupt and reset sequences, and randomized accesses against a register model.
module tb_apb_i2c_regbank;

  localparam int WAIT_MAX = 15;

  logic        PCLK, PRESET, PSELx, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA, READ_DATA_ON_RX, WRITE_DATA_ON_TX;
  logic        PREADY, PSLVERR, TX_FULL, TX_EMPTY, RX_EMPTY, ERROR;
  logic        WR_ENA, RD_ENA, INT_TX, INT_RX, INT_ERR;
  logic [13:0] I2C_CONFIG, I2C_TIMEOUT;

  apb_i2c_regbank #(.DATA_W(32), .CFG_W(14), .TO_W(14), .WAIT_MAX(WAIT_MAX)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .READ_DATA_ON_RX(READ_DATA_ON_RX), .TX_FULL(TX_FULL), .TX_EMPTY(TX_EMPTY),
    .RX_EMPTY(RX_EMPTY), .ERROR(ERROR), .WRITE_DATA_ON_TX(WRITE_DATA_ON_TX),
    .WR_ENA(WR_ENA), .RD_ENA(RD_ENA), .I2C_CONFIG(I2C_CONFIG), .I2C_TIMEOUT(I2C_TIMEOUT),
    .INT_TX(INT_TX), .INT_RX(INT_RX), .INT_ERR(INT_ERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_chk = 0, n_fail = 0;
  int wr_cnt = 0, rd_cnt = 0;
  logic [31:0] last_tx = '0;

  always @(negedge PCLK) begin
    if (WR_ENA) begin wr_cnt++; last_tx = WRITE_DATA_ON_TX; end
    if (RD_ENA) rd_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic set_blk(input bit rx, input bit v);
    if (rx) RX_EMPTY = v; else TX_FULL = v;
  endtask

  // One APB transfer; the chosen FIFO flag is held blocking for the first blk_n access cycles.
  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     input int blk_n, input bit blk_rx, input bit rise_err,
                     output logic [31:0] rd, output bit err, output int cyc);
    @(posedge PCLK); #1;
    PSELx = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1; set_blk(blk_rx, blk_n > 0);
    if (rise_err) ERROR = 1;
    cyc = 0; rd = '0; err = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge PCLK);
      if (PREADY) begin cyc = i; rd = PRDATA; err = PSLVERR; break; end
      @(posedge PCLK); #1;
      set_blk(blk_rx, i < blk_n);
    end
    @(posedge PCLK); #1;
    PSELx = 0; PENABLE = 0; set_blk(blk_rx, 0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          err;
    bit          chk_rd;
    logic [31:0] rd;
  } vec_t;

  vec_t vt[14];

  logic [31:0] rd;
  bit          err;
  int          cyc, w0, r0;
  logic [13:0] m_cfg, m_to;
  logic [2:0]  m_en;

  initial begin
    vt[0]  = '{1'b1, 32'h08,  32'h0000_1234, 1'b0, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 32'h08,  32'h0,         1'b0, 1'b1, 32'h1234};
    vt[2]  = '{1'b1, 32'h0C,  32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0};
    vt[3]  = '{1'b0, 32'h0C,  32'h0,         1'b0, 1'b1, 32'h3FFF};
    vt[4]  = '{1'b1, 32'h1C,  32'hDEAD,      1'b1, 1'b1, 32'h0};
    vt[5]  = '{1'b0, 32'h1C,  32'h0,         1'b1, 1'b1, 32'h0};
    vt[6]  = '{1'b1, 32'h10,  32'h5,         1'b1, 1'b1, 32'h0};
    vt[7]  = '{1'b1, 32'h04,  32'h5,         1'b1, 1'b1, 32'h0};
    vt[8]  = '{1'b0, 32'h00,  32'h0,         1'b1, 1'b1, 32'h0};
    vt[9]  = '{1'b1, 32'h09,  32'h1,         1'b1, 1'b1, 32'h0};
    vt[10] = '{1'b1, 32'h108, 32'h1,         1'b1, 1'b1, 32'h0};
    vt[11] = '{1'b0, 32'h08,  32'h0,         1'b0, 1'b1, 32'h1234};
    vt[12] = '{1'b1, 32'h14,  32'hFF,        1'b0, 1'b0, 32'h0};
    vt[13] = '{1'b0, 32'h14,  32'h0,         1'b0, 1'b1, 32'h7};

    PRESET = 1; PSELx = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    READ_DATA_ON_RX = 0; TX_FULL = 0; TX_EMPTY = 0; RX_EMPTY = 0; ERROR = 0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 0;
    @(negedge PCLK);
    chk("reset_pready", PREADY, 0);
    chk("reset_pslverr", PSLVERR, 0);
    chk("reset_prdata", PRDATA, 0);
    chk("reset_config", I2C_CONFIG, 0);
    chk("reset_timeout", I2C_TIMEOUT, 0);
    chk("reset_ints", {INT_TX, INT_RX, INT_ERR, WR_ENA, RD_ENA}, 0);

    // Register table, including decode errors that must not disturb registers.
    for (int i = 0; i < 14; i++) begin
      apb(vt[i].wr, vt[i].addr, vt[i].wd, 0, 0, 0, rd, err, cyc);
      chk($sformatf("vec%0d_cycles", i), cyc, 2);
      chk($sformatf("vec%0d_err", i), err, vt[i].err);
      if (vt[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vt[i].rd);
    end
    chk("vec_config", I2C_CONFIG, 14'h1234);
    chk("vec_timeout", I2C_TIMEOUT, 14'h3FFF);

    // TX push blocked by TX_FULL for 3 cycles.
    w0 = wr_cnt;
    apb(1, 32'h00, 32'hA5, 3, 0, 0, rd, err, cyc);
    chk("txwait_cycles", cyc, 5);
    chk("txwait_err", err, 0);
    chk("txwait_pulses", wr_cnt - w0, 1);
    chk("txwait_data", last_tx, 32'hA5);

    // RX pop times out while RX_EMPTY stays high.
    r0 = rd_cnt;
    READ_DATA_ON_RX = 32'h5A5A_1111;
    apb(0, 32'h04, 32'h0, 100, 1, 0, rd, err, cyc);
    chk("rxto_cycles", cyc, WAIT_MAX + 2);
    chk("rxto_err", err, 1);
    chk("rxto_rdata", rd, 0);
    chk("rxto_pulses", rd_cnt - r0, 0);

    // RX pop released after 2 blocked cycles.
    r0 = rd_cnt;
    apb(0, 32'h04, 32'h0, 2, 1, 0, rd, err, cyc);
    chk("rxok_cycles", cyc, 4);
    chk("rxok_err", err, 0);
    chk("rxok_rdata", rd, 32'h5A5A_1111);
    chk("rxok_pulses", rd_cnt - r0, 1);

    // Interrupts: masking, latency, sticky status, set-wins-over-W1C.
    apb(1, 32'h18, 32'h7, 0, 0, 0, rd, err, cyc);
    apb(1, 32'h14, 32'h6, 0, 0, 0, rd, err, cyc);
    @(posedge PCLK); #1 TX_EMPTY = 1;
    repeat (3) @(negedge PCLK);
    chk("irq_tx_masked", INT_TX, 0);
    apb(0, 32'h18, 32'h0, 0, 0, 0, rd, err, cyc);
    chk("irq_stat_tx", rd, 32'h1);
    apb(1, 32'h14, 32'h7, 0, 0, 0, rd, err, cyc);
    @(negedge PCLK);
    chk("irq_tx_unmasked", {INT_TX, INT_RX, INT_ERR}, 3'b100);
    apb(1, 32'h18, 32'h1, 0, 0, 0, rd, err, cyc);
    @(posedge PCLK); #1 ERROR = 1;
    @(negedge PCLK);
    chk("irq_err_c0", INT_ERR, 0);
    @(negedge PCLK);
    chk("irq_err_c1", INT_ERR, 0);
    @(negedge PCLK);
    chk("irq_err_c2", INT_ERR, 1);
    apb(0, 32'h10, 32'h0, 0, 0, 0, rd, err, cyc);
    chk("status_read", rd, 32'hA);
    ERROR = 0;
    repeat (2) @(posedge PCLK);
    apb(1, 32'h18, 32'h4, 0, 0, 1, rd, err, cyc);
    apb(0, 32'h18, 32'h0, 0, 0, 0, rd, err, cyc);
    chk("w1c_vs_set", rd, 32'h4);
    chk("w1c_vs_set_int", INT_ERR, 1);
    apb(1, 32'h18, 32'h4, 0, 0, 0, rd, err, cyc);
    apb(0, 32'h18, 32'h0, 0, 0, 0, rd, err, cyc);
    chk("w1c_clear", rd, 32'h0);
    repeat (2) @(negedge PCLK);
    chk("w1c_clear_int", INT_ERR, 0);

    // Randomized accesses against a register-level model.
    m_cfg = I2C_CONFIG; m_to = I2C_TIMEOUT; m_en = 3'h7;
    for (int it = 0; it < 60; it++) begin
      int off, blk;
      bit wr, e_err, fifo, e_to;
      logic [31:0] addr, wd, e_rd;
      int e_cyc;
      bit do_rd;
      off  = $urandom_range(0, 8);
      wr   = $urandom_range(0, 1);
      wd   = $urandom;
      addr = (off < 8) ? 32'(off * 4) : 32'h0000_0022;
      READ_DATA_ON_RX = $urandom;
      e_err = (off >= 7) || (wr && (off == 1 || off == 4)) || (!wr && off == 0);
      fifo  = !e_err && ((wr && off == 0) || (!wr && off == 1));
      blk   = fifo ? $urandom_range(0, 18) : 0;
      e_to  = fifo && blk > WAIT_MAX;
      e_cyc = (blk == 0) ? 2 : ((blk > WAIT_MAX) ? WAIT_MAX + 2 : blk + 2);
      do_rd = 1; e_rd = '0;
      if (!e_err && !e_to) begin
        if (wr) do_rd = 0;
        else case (off)
          1: e_rd = READ_DATA_ON_RX;
          2: e_rd = 32'(m_cfg);
          3: e_rd = 32'(m_to);
          5: e_rd = 32'(m_en);
          default: do_rd = 0;
        endcase
      end
      w0 = wr_cnt; r0 = rd_cnt;
      apb(wr, addr, wd, blk, !wr, 0, rd, err, cyc);
      if (wr && !e_err) begin
        if (off == 2) m_cfg = wd[13:0];
        if (off == 3) m_to  = wd[13:0];
        if (off == 5) m_en  = wd[2:0];
      end
      chk($sformatf("rnd%0d_cycles", it), cyc, e_cyc);
      chk($sformatf("rnd%0d_err", it), err, e_err || e_to);
      if (do_rd) chk($sformatf("rnd%0d_rdata", it), rd, e_rd);
      chk($sformatf("rnd%0d_push", it), wr_cnt - w0, (fifo && wr && !e_to) ? 1 : 0);
      chk($sformatf("rnd%0d_pop", it), rd_cnt - r0, (fifo && !wr && !e_to) ? 1 : 0);
      if (fifo && wr && !e_to) chk($sformatf("rnd%0d_txdata", it), last_tx, wd);
      chk($sformatf("rnd%0d_config", it), I2C_CONFIG, m_cfg);
      chk($sformatf("rnd%0d_timeout", it), I2C_TIMEOUT, m_to);
    end

    // Reset while a TX push is stalled in WAIT.
    apb(1, 32'h08, 32'h1234, 0, 0, 0, rd, err, cyc);
    w0 = wr_cnt;
    @(posedge PCLK); #1;
    PSELx = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h0; PWDATA = 32'h77; TX_FULL = 1;
    @(posedge PCLK); #1 PENABLE = 1;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    chk("rst_wait_pready", PREADY, 0);
    @(posedge PCLK); #1 PRESET = 1;
    @(posedge PCLK); #1 PRESET = 0; PSELx = 0; PENABLE = 0; TX_FULL = 0;
    @(negedge PCLK);
    chk("rst_mid_pready", {PREADY, PSLVERR}, 0);
    chk("rst_mid_config", I2C_CONFIG, 0);
    chk("rst_mid_prdata", PRDATA, 0);
    chk("rst_mid_ints", {INT_TX, INT_RX, INT_ERR}, 0);
    repeat (3) @(negedge PCLK);
    chk("rst_mid_nopush", wr_cnt - w0, 0);
    apb(0, 32'h18, 32'h0, 0, 0, 0, rd, err, cyc);
    chk("rst_after_stat", rd, 0);
    chk("rst_after_cycles", cyc, 2);
    apb(1, 32'h08, 32'h0ABC, 0, 0, 0, rd, err, cyc);
    chk("rst_after_err", err, 0);
    chk("rst_after_config", I2C_CONFIG, 14'h0ABC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
